// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receiver (and a future transmitter).
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    function automatic logic exp_parity(input logic data_xor, input int mode);
        return (mode == PAR_ODD) ? ~data_xor : data_xor;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-clock tick every c_div clocks plus a wrapping sample index.
module uart_baud_tick #(
    parameter int c_div        = 54,
    parameter int c_oversample = 16,
    localparam int CW = $clog2(c_div + 1),
    localparam int SW = $clog2(c_oversample)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          restart_i,
    output logic          tick_o,
    output logic [SW-1:0] sample_idx_o
);

    localparam logic [CW-1:0] CNT_LAST = CW'(c_div - 1);
    localparam logic [SW-1:0] IDX_LAST = SW'(c_oversample - 1);

    if (c_div < 1) begin : g_bad_div
        $error("uart_baud_tick: divider must be at least 1");
    end

    logic [CW-1:0] r_cnt;
    logic [SW-1:0] r_idx;
    logic          w_tick;

    assign w_tick = (r_cnt == CNT_LAST) && !restart_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (restart_i) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else begin
            r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
            if (w_tick)
                r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end
    end

    assign tick_o       = w_tick;
    assign sample_idx_o = r_idx;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver with majority-vote bit decisions,
// valid/ready output and parity/framing/overrun reporting.
//
// state  | meaning
// IDLE   | line idle, waiting for a low level (and for high again after a break)
// START  | start bit; false start returns to IDLE
// DATA   | shifting in data bits, LSB first
// PARITY | checking the parity bit against the data XOR
// STOP   | stop bit(s); leaves at the last stop decision, half a bit early
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int c_clkfreq    = 100_000_000,
    parameter int c_baudrate   = 115_200,
    parameter int c_oversample = 16,
    parameter int c_databits   = 8,
    parameter int c_parity     = 0,
    parameter int c_stopbits   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_in_i,
    output logic [c_databits-1:0] dout_o,
    output logic                  dout_valid_o,
    input  logic                  dout_ready_i,
    output logic                  parity_err_o,
    output logic                  frame_err_o,
    output logic                  overrun_err_o
);

    localparam int TICK_DIV = c_clkfreq / (c_baudrate * c_oversample);
    localparam int SW       = $clog2(c_oversample);
    localparam int BW       = $clog2(c_databits + 1);
    localparam int M        = c_oversample / 2;

    localparam logic [SW-1:0] IDX_A     = SW'(M - 1);
    localparam logic [SW-1:0] IDX_B     = SW'(M);
    localparam logic [SW-1:0] IDX_C     = SW'(M + 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(c_databits - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(c_stopbits - 1);

    if (c_oversample < 8 || (c_oversample % 2) != 0 || c_databits < 5 || c_databits > 9 ||
        c_parity < 0 || c_parity > 2 || c_stopbits < 1 || c_stopbits > 2) begin : g_bad_param
        $error("uart_rx_param: illegal parameter combination");
    end

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_sync1;
    logic                  r_rxs;
    logic                  r_s0;
    logic                  r_s1;
    logic [BW-1:0]         r_bit_cnt;
    logic [c_databits-1:0] r_shift;
    logic                  r_xor;
    logic                  r_par_err;
    logic                  r_frm_err;
    logic                  r_need_high;
    logic [c_databits-1:0] r_dout;
    logic                  r_valid;
    logic                  r_perr;
    logic                  r_ferr;
    logic                  r_ovr;
    logic                  w_tick;
    logic [SW-1:0]         w_idx;
    logic                  w_dec;
    logic                  w_maj;
    logic                  w_restart;
    logic                  w_done;

    uart_baud_tick #(
        .c_div        (TICK_DIV),
        .c_oversample (c_oversample)
    ) u_tick (
        .clk          (clk),
        .rst_n        (rst_n),
        .restart_i    (w_restart),
        .tick_o       (w_tick),
        .sample_idx_o (w_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_rxs   <= 1'b1;
        end else begin
            r_sync1 <= rx_in_i;
            r_rxs   <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s0 <= 1'b1;
            r_s1 <= 1'b1;
        end else if (w_tick) begin
            if (w_idx == IDX_A) r_s0 <= r_rxs;
            if (w_idx == IDX_B) r_s1 <= r_rxs;
        end
    end

    assign w_dec = w_tick && (w_idx == IDX_C);
    assign w_maj = (r_s0 & r_s1) | (r_s0 & r_rxs) | (r_s1 & r_rxs);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_restart   = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (!r_rxs && !r_need_high) begin
                    w_state_nxt = START;
                    w_restart   = 1'b1;
                end
            end
            START: begin
                if (w_dec) w_state_nxt = w_maj ? IDLE : DATA;
            end
            DATA: begin
                if (w_dec && r_bit_cnt == LAST_DATA)
                    w_state_nxt = (c_parity != PAR_NONE) ? PARITY : STOP;
            end
            PARITY: begin
                if (w_dec) w_state_nxt = STOP;
            end
            STOP: begin
                if (w_dec && r_bit_cnt == LAST_STOP) begin
                    w_state_nxt = IDLE;
                    w_done      = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // A stop bit sampled low at the end of a frame may be a break: hold off new starts until the line is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_xor       <= 1'b0;
            r_par_err   <= 1'b0;
            r_frm_err   <= 1'b0;
            r_need_high <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_rxs) r_need_high <= 1'b0;
                end
                START: begin
                    if (w_dec && !w_maj) begin
                        r_bit_cnt <= '0;
                        r_xor     <= 1'b0;
                        r_par_err <= 1'b0;
                        r_frm_err <= 1'b0;
                    end
                end
                DATA: begin
                    if (w_dec) begin
                        r_shift   <= {w_maj, r_shift[c_databits-1:1]};
                        r_xor     <= r_xor ^ w_maj;
                        r_bit_cnt <= (r_bit_cnt == LAST_DATA) ? '0 : r_bit_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (w_dec) r_par_err <= (w_maj != exp_parity(r_xor, c_parity));
                end
                STOP: begin
                    if (w_dec) begin
                        r_frm_err <= r_frm_err | ~w_maj;
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == LAST_STOP) r_need_high <= ~w_maj;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout  <= '0;
            r_valid <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else if (w_done) begin
            r_dout  <= r_shift;
            r_perr  <= r_par_err;
            r_ferr  <= r_frm_err | ~w_maj;
            r_valid <= 1'b1;
            r_ovr   <= r_valid && !dout_ready_i;
        end else begin
            r_ovr <= 1'b0;
            if (r_valid && dout_ready_i) r_valid <= 1'b0;
        end
    end

    assign dout_o        = r_dout;
    assign dout_valid_o  = r_valid;
    assign parity_err_o  = r_perr;
    assign frame_err_o   = r_ferr;
    assign overrun_err_o = r_ovr;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: four parameterisations driven with directed and random frames,
// checked against a frame-level model of what each sent frame should deliver.
module tb_uart_rx_param;

    logic       clk;
    logic       rst_n;
    logic [3:0] rx;
    logic [3:0] rdy;
    logic [3:0] valid;
    logic [3:0] perr;
    logic [3:0] ferr;
    logic [3:0] ovr;
    logic [7:0] dout0;
    logic [6:0] dout1;
    logic [7:0] dout2;
    logic [8:0] dout3;
    logic [15:0] mdout [4];

    int checks   = 0;
    int failures = 0;

    // per instance: data bits, parity mode, stop bits, clocks per bit
    int nd_a [4] = '{8, 7, 8, 9};
    int par_a[4] = '{0, 1, 0, 2};
    int ns_a [4] = '{1, 1, 2, 1};
    int bl_a [4] = '{864, 64, 64, 64};

    typedef struct {
        int          inst;
        logic [15:0] d;
        logic        pe;
        logic        fe;
    } word_t;
    word_t wq[$];

    int   vcnt [4] = '{0, 0, 0, 0};
    int   ovcnt[4] = '{0, 0, 0, 0};
    logic [3:0] pv = 4'b0;
    logic [3:0] pr = 4'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_rx_param u_d0 (
        .clk(clk), .rst_n(rst_n), .rx_in_i(rx[0]), .dout_o(dout0), .dout_valid_o(valid[0]),
        .dout_ready_i(rdy[0]), .parity_err_o(perr[0]), .frame_err_o(ferr[0]), .overrun_err_o(ovr[0])
    );

    uart_rx_param #(.c_clkfreq(7_372_800), .c_databits(7), .c_parity(1), .c_stopbits(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .rx_in_i(rx[1]), .dout_o(dout1), .dout_valid_o(valid[1]),
        .dout_ready_i(rdy[1]), .parity_err_o(perr[1]), .frame_err_o(ferr[1]), .overrun_err_o(ovr[1])
    );

    uart_rx_param #(.c_clkfreq(7_372_800), .c_databits(8), .c_parity(0), .c_stopbits(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .rx_in_i(rx[2]), .dout_o(dout2), .dout_valid_o(valid[2]),
        .dout_ready_i(rdy[2]), .parity_err_o(perr[2]), .frame_err_o(ferr[2]), .overrun_err_o(ovr[2])
    );

    uart_rx_param #(.c_clkfreq(7_372_800), .c_databits(9), .c_parity(2), .c_stopbits(1)) u_d3 (
        .clk(clk), .rst_n(rst_n), .rx_in_i(rx[3]), .dout_o(dout3), .dout_valid_o(valid[3]),
        .dout_ready_i(rdy[3]), .parity_err_o(perr[3]), .frame_err_o(ferr[3]), .overrun_err_o(ovr[3])
    );

    assign mdout[0] = {8'h00, dout0};
    assign mdout[1] = {9'h000, dout1};
    assign mdout[2] = {8'h00, dout2};
    assign mdout[3] = {7'h00, dout3};

    // A word is newly presented when valid rises, follows an accepted word, or overwrote one.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (valid[k] && (!pv[k] || pr[k] || ovr[k]))
                wq.push_back('{k, mdout[k], perr[k], ferr[k]});
            if (valid[k]) vcnt[k]++;
            if (ovr[k]) ovcnt[k]++;
        end
        pv = valid;
        pr = rdy;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_raw(input int inst, input logic [15:0] data, input logic pbit,
                            input logic [1:0] stops, input int idle_bits);
        int bl;
        bl = bl_a[inst];
        rx[inst] = 1'b0;
        clks(bl);
        for (int i = 0; i < nd_a[inst]; i++) begin
            rx[inst] = data[i];
            clks(bl);
        end
        if (par_a[inst] != 0) begin
            rx[inst] = pbit;
            clks(bl);
        end
        for (int s = 0; s < ns_a[inst]; s++) begin
            rx[inst] = stops[s];
            clks(bl);
        end
        if (idle_bits > 0) begin
            rx[inst] = 1'b1;
            clks(idle_bits * bl);
        end
    endtask

    task automatic model(input int inst, input logic [15:0] data, input logic pbit,
                         input logic [1:0] stops, output logic [15:0] d, output logic pe,
                         output logic fe);
        logic [15:0] mask;
        mask = 16'((32'd1 << nd_a[inst]) - 1);
        d    = data & mask;
        pe   = (par_a[inst] != 0) && (pbit != ((^d) ^ (par_a[inst] == 2)));
        fe   = 1'b0;
        for (int s = 0; s < ns_a[inst]; s++)
            if (!stops[s]) fe = 1'b1;
    endtask

    task automatic check_word(input string tag, input int inst, input logic [15:0] d,
                              input logic pe, input logic fe);
        word_t w;
        chk({tag, ".present"}, 32'(wq.size() > 0), 32'd1);
        if (wq.size() > 0) begin
            w = wq.pop_front();
            chk({tag, ".inst"}, w.inst, inst);
            chk({tag, ".dout"}, w.d, d);
            chk({tag, ".parity_err"}, w.pe, pe);
            chk({tag, ".frame_err"}, w.fe, fe);
        end
    endtask

    task automatic frame(input string tag, input int inst, input logic [15:0] data,
                         input logic pbit, input logic [1:0] stops);
        logic [15:0] ed;
        logic        epe;
        logic        efe;
        send_raw(inst, data, pbit, stops, 2);
        model(inst, data, pbit, stops, ed, epe, efe);
        check_word(tag, inst, ed, epe, efe);
        chk({tag, ".single"}, wq.size(), 0);
    endtask

    initial begin
        int          v0;
        int          o0;
        int          inst;
        logic [15:0] data;
        logic [15:0] md;
        logic        pb;
        logic [1:0]  st;

        rst_n = 1'b0;
        rx    = 4'hF;
        rdy   = 4'hF;
        clks(5);
        chk("reset.valid", valid, 4'h0);
        chk("reset.flags", {perr, ferr, ovr}, 12'h000);
        chk("reset.dout", {dout0, dout1, dout2, dout3}, 32'h0);
        rst_n = 1'b1;
        clks(20);

        v0 = vcnt[0];
        frame("d0_a5", 0, 16'h00A5, 1'b0, 2'b11);
        chk("d0_a5.valid_cycles", vcnt[0] - v0, 1);

        frame("d1_par_bad", 1, 16'h0003, 1'b1, 2'b11);
        frame("d1_par_ok", 1, 16'h0003, 1'b0, 2'b11);

        send_raw(2, 16'h005A, 1'b0, 2'b01, 0);
        rx[2] = 1'b0;
        clks(20 * bl_a[2]);
        check_word("d2_break", 2, 16'h005A, 1'b0, 1'b1);
        chk("d2_break.no_more", wq.size(), 0);
        rx[2] = 1'b1;
        clks(3 * bl_a[2]);
        chk("d2_break.idle_after", wq.size(), 0);
        frame("d2_after_break", 2, 16'h00C3, 1'b0, 2'b11);

        v0 = vcnt[0];
        rx[0] = 1'b0;
        clks(162);
        rx[0] = 1'b1;
        clks(2 * bl_a[0]);
        chk("glitch.no_word", wq.size(), 0);
        chk("glitch.valid_cycles", vcnt[0] - v0, 0);

        rdy[2] = 1'b0;
        o0 = ovcnt[2];
        send_raw(2, 16'h0011, 1'b0, 2'b11, 0);
        send_raw(2, 16'h0022, 1'b0, 2'b11, 1);
        check_word("ovr_first", 2, 16'h0011, 1'b0, 1'b0);
        check_word("ovr_second", 2, 16'h0022, 1'b0, 1'b0);
        chk("ovr.pulses", ovcnt[2] - o0, 1);
        chk("ovr.valid_held", valid[2], 1'b1);
        chk("ovr.dout", dout2, 8'h22);
        rdy[2] = 1'b1;
        clks(1);
        rdy[2] = 1'b0;
        @(negedge clk);
        chk("ovr.valid_drop", valid[2], 1'b0);
        clks(1);
        rdy[2] = 1'b1;

        rx[2] = 1'b0;
        clks(bl_a[2]);
        rx[2] = 1'b1;
        clks(4 * bl_a[2] + 10);
        rst_n = 1'b0;
        clks(3);
        chk("rst_mid.valid", valid, 4'h0);
        rst_n = 1'b1;
        clks(3 * bl_a[2]);
        chk("rst_mid.no_word", wq.size(), 0);
        frame("rst_mid_3c", 2, 16'h003C, 1'b0, 2'b11);

        for (int n = 0; n < 18; n++) begin
            inst = (n % 3 == 0) ? 1 : ((n % 3 == 1) ? 3 : 2);
            data = 16'($urandom);
            md   = data & 16'((32'd1 << nd_a[inst]) - 1);
            pb   = (^md) ^ (par_a[inst] == 2);
            if ($urandom_range(3) == 0) pb = ~pb;
            st   = 2'b11;
            if ($urandom_range(3) == 0) st[$urandom_range(ns_a[inst] - 1)] = 1'b0;
            frame($sformatf("rand%0d_i%0d", n, inst), inst, data, pb, st);
        end
        frame("d0_rand", 0, 16'($urandom), 1'b0, 2'b11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised, oversampling UART receiver; the next generation of the team's fixed 8N1 receiver. It supports a configurable data width, an optional even/odd parity bit and 1 or 2 stop bits. Each bit is decided by a 3-sample majority vote. Received words go to a downstream consumer through a valid/ready handshake, and the block reports parity, framing and overrun errors. It sits between the synchronised serial pin and a byte FIFO or register interface.

Parameters:
c_clkfreq, 100_000_000, system clock frequency in Hz
c_baudrate, 115_200, line baud rate in bits/s
c_oversample, 16, samples per bit; even, >= 8
c_databits, 8, data bits per frame; legal range 5..9
c_parity, 0, 0 = none, 1 = even, 2 = odd
c_stopbits, 1, 1 or 2

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous assert, active-low
rx_in_i  in  1  raw serial line; idle high; asynchronous to clk
dout_o  out  c_databits  received word, LSB = first bit on the line
dout_valid_o  out  1  dout_o and error flags valid
dout_ready_i  in  1  consumer accepts the word
parity_err_o  out  1  parity mismatch on the held word; qualified by dout_valid_o
frame_err_o  out  1  a stop bit sampled low on the held word; qualified by dout_valid_o
overrun_err_o  out  1  one-cycle pulse: a word was lost because the previous word was not consumed

Behaviour:
- Reset: clk and rst_n (async, active-low) as already decided. All outputs reset to 0. State = IDLE. Synchroniser flops reset to 1.
- Input path: 2-flop synchroniser on rx_in_i. All logic uses the synchronised value rxs.
- Tick generator:
  - TICK_DIV = c_clkfreq / (c_baudrate * c_oversample), integer division.
  - Emits a 1-clk tick every TICK_DIV clocks. Elaboration fails if TICK_DIV < 1.
  - The tick counter and the sample counter (0..c_oversample-1) restart when a start edge is detected in IDLE.
- Majority vote: rxs is sampled on ticks M-1, M and M+1, where M = c_oversample/2. The bit value is the majority of the 3 samples. The bit is decided on tick M+1.
- States:
  - IDLE: rxs == 0 -> START.
  - START: on decision, majority 0 -> DATA (bit index 0). Majority 1 -> IDLE (false start). No output on a false start.
  - DATA: each decision shifts the bit in at the MSB, right-shift, LSB first. After c_databits bits -> PARITY if c_parity != 0, else STOP.
  - PARITY: decision compared with the running XOR of the data bits. Even: expected parity bit = XOR. Odd: expected = ~XOR. Records a mismatch.
  - STOP: one decision per stop bit. Any 0 sets the frame error. After the last stop decision -> IDLE immediately (half-bit early, so the receiver can resync to back-to-back frames).
- Output: on the cycle after the last stop decision:
  - dout_o, parity_err_o and frame_err_o load.
  - dout_valid_o = 1.
  - End-to-end latency from the mid-point of the last stop bit = 1 clk, plus the 2-flop synchroniser.
- Handshake:
  - dout_valid_o holds, and dout_o and the error flags stay stable, until a cycle with dout_ready_i = 1. dout_valid_o drops on the next cycle.
  - dout_ready_i while valid = 0 is ignored.
- Overrun: a new word completes while valid = 1 and ready = 0:
  - The new word overwrites dout_o and the error flags.
  - valid stays 1.
  - overrun_err_o pulses 1 clk.
- Simultaneous completion and ready = 1: the new word loads, valid stays 1, no overrun.
- Frame error with the line stuck low (break): the word is still delivered with frame_err_o = 1. The FSM then waits in IDLE for rxs == 1 before accepting a new start.
- Reset mid-frame: the partial word is discarded, no valid is produced, and the FSM returns to IDLE.
- Widths: tick counter $clog2(TICK_DIV+1); bit counter $clog2(c_databits+1). No counter wraps within a frame.

Decomposition:
- Package uart_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP)
  - parity mode localparams (PAR_NONE, PAR_EVEN, PAR_ODD)
  - function returning the expected parity bit
- Sub-module uart_baud_tick:
  - parameters: divider and oversample
  - inputs: clk, rst_n, restart
  - outputs: tick and sample index
  - reusable by a future matching transmitter

Test Plan:
- Defaults (TICK_DIV = 54, bit = 864 clk); send 8N1 0xA5, ready held 1 -> dout_o = 0xA5, valid for 1 clk, parity/frame err = 0.
- c_parity = 1, c_databits = 7; send 0x03 with parity bit 1 -> dout_o = 0x03, parity_err_o = 1. Repeat with parity bit 0 -> parity_err_o = 0.
- c_stopbits = 2; send 0x5A with second stop bit low -> frame_err_o = 1. Line then held low 20 bit times -> exactly one word and no further valid until the line returns high.
- Low glitch lasting 3 ticks (162 clk) on an idle line -> no state leaves IDLE beyond START, dout_valid_o stays 0.
- Send 0x11 then 0x22 back-to-back with ready = 0 -> overrun_err_o pulses once, dout_o = 0x22, valid held. Then ready = 1 for 1 clk -> valid drops.
- Assert rst_n = 0 for 3 clk mid-data of 0xFF, then send 0x3C -> only 0x3C delivered, with correct values.
